// File: rtl/tile_map_pkg.sv
// Shared types for the tile-map renderer.
//   tile_code_t : default-width tile code (4 bits)
//   TILE_EMPTY  : code of a blank tile, also the value written by the clear pass
//   map_state_t : controller states, CLEAR (map wipe after reset) and RUN
package tile_map_pkg;

  localparam int TILE_CODE_W = 4;

  typedef logic [TILE_CODE_W-1:0] tile_code_t;

  localparam tile_code_t TILE_EMPTY = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } map_state_t;

endpackage

// File: rtl/tile_map_ram.sv
// Single-port synchronous tile-map RAM, one access per cycle, 1-cycle read.
// Read-first: a write cycle returns the old word, which the parent never uses.
// Contents are not reset; the parent wipes them with a clear pass.
// Ports:
//   clk  : clock
//   we   : write enable
//   addr : word address (reads and writes)
//   wd   : write data
//   rd   : registered read data for addr of the previous cycle
module tile_map_ram
  import tile_map_pkg::*;
#(
  parameter int DEPTH  = 1200,
  parameter int ADDR_W = 11,
  parameter int CODE_W = TILE_CODE_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CODE_W-1:0] wd,
  output logic [CODE_W-1:0] rd
);

  logic [CODE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= mem[addr];
  end

endmodule

// File: rtl/tile_map_renderer.sv
// Tile-map fetch engine: maps a pixel coordinate to its tile code and in-tile
// offset with a fixed 2-cycle latency, and owns the tile map RAM.  After reset
// the whole map is wiped to TILE_EMPTY (busy high), then normal operation runs.
// A req/ack write port updates single tiles; it only gets the RAM port in
// cycles where no in-range stage-0 pixel needs a read.
// Optional macro TILE_SCROLL_EN adds input scroll_x for a wrapping horizontal
// scroll of the map.
// Ports:
//   CLOCK_50, reset          : clock, asynchronous active-high reset
//   pix_valid, x, y          : pixel request
//   out_valid, out_code      : pixel result, 2 cycles after pix_valid
//   out_loc_x, out_loc_y     : pixel offset inside its tile
//   wr_req, wr_col, wr_row,
//   wr_code                  : tile write request, held until wr_ack
//   wr_ack, wr_err           : request consumed / target was out of range
//   busy                     : map clear in progress
//   scroll_x (TILE_SCROLL_EN): horizontal scroll offset in pixels
module tile_map_renderer
  import tile_map_pkg::*;
#(
  parameter int TILE_LOG2 = 4,
  parameter int MAP_COLS  = 40,
  parameter int MAP_ROWS  = 30,
  parameter int CODE_W    = 4,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  localparam int COL_W    = $clog2(MAP_COLS),
  localparam int ROW_W    = $clog2(MAP_ROWS)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic [X_W-1:0]       x,
  input  logic [Y_W-1:0]       y,
`ifdef TILE_SCROLL_EN
  input  logic [X_W-1:0]       scroll_x,
`endif
  output logic                 out_valid,
  output logic [CODE_W-1:0]    out_code,
  output logic [TILE_LOG2-1:0] out_loc_x,
  output logic [TILE_LOG2-1:0] out_loc_y,
  input  logic                 wr_req,
  input  logic [COL_W-1:0]     wr_col,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [CODE_W-1:0]    wr_code,
  output logic                 wr_ack,
  output logic                 wr_err,
  output logic                 busy
);

  localparam int DEPTH  = MAP_ROWS * MAP_COLS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CX_W   = X_W - TILE_LOG2;
  localparam int RY_W   = Y_W - TILE_LOG2;

  logic [X_W-1:0] xe;

`ifdef TILE_SCROLL_EN
  localparam int SPAN_X = MAP_COLS << TILE_LOG2;

  // One extra bit keeps the carry of x + scroll_x before wrapping.
  function automatic logic [X_W-1:0] wrap_x(input logic [X_W-1:0] px,
                                            input logic [X_W-1:0] sx);
    logic [X_W:0] sum;
    sum = {1'b0, px} + {1'b0, sx};
    return X_W'(sum % (X_W+1)'(SPAN_X));
  endfunction

  assign xe = wrap_x(x, scroll_x);
`else
  assign xe = x;
`endif

  map_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_addr;

  logic                 vld_p0;
  logic [CX_W-1:0]      col_p0;
  logic [RY_W-1:0]      row_p0;
  logic [TILE_LOG2-1:0] lx_p0, ly_p0;
  logic                 inr_p0, pix_rd;
  logic [ADDR_W-1:0]    addr_p0;

  logic                 vld_p1, rd_p1;
  logic [TILE_LOG2-1:0] lx_p1, ly_p1;

  logic                 wr_oor;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [CODE_W-1:0]    ram_wd, ram_rd;

  // ---- stage 0: capture pixel, split into tile index and offset ----
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= pix_valid;
  end

  always_ff @(posedge CLOCK_50) begin
    col_p0 <= xe[X_W-1:TILE_LOG2];
    row_p0 <= y[Y_W-1:TILE_LOG2];
    lx_p0  <= xe[TILE_LOG2-1:0];
    ly_p0  <= y[TILE_LOG2-1:0];
  end

  // Range check uses the full-width column so x beyond the map is caught.
  assign inr_p0  = (int'(col_p0) < MAP_COLS) && (int'(row_p0) < MAP_ROWS);
  assign addr_p0 = ADDR_W'(row_p0) * ADDR_W'(MAP_COLS) + ADDR_W'(col_p0);
  assign pix_rd  = vld_p0 && inr_p0 && (state == RUN);

  assign wr_oor  = (int'(wr_col) >= MAP_COLS) || (int'(wr_row) >= MAP_ROWS);
  assign wr_addr = ADDR_W'(wr_row) * ADDR_W'(MAP_COLS) + ADDR_W'(wr_col);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                clr_addr <= '0;
    else if (state == CLEAR)  clr_addr <= clr_addr + ADDR_W'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:   if (clr_addr == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // RAM port owner: clear pass, else pixel read, else pending tile write.
  always_comb begin
    busy     = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wd   = '0;
    wr_ack   = 1'b0;
    wr_err   = 1'b0;
    unique case (state)
      CLEAR: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        ram_wd   = CODE_W'(TILE_EMPTY);
      end
      RUN: begin
        if (pix_rd) begin
          ram_addr = addr_p0;
        end else if (wr_req) begin
          wr_ack = 1'b1;
          wr_err = wr_oor;
          if (!wr_oor) begin
            ram_we   = 1'b1;
            ram_addr = wr_addr;
            ram_wd   = wr_code;
          end
        end
      end
      default: ;
    endcase
  end

  // ---- stage 1: RAM read ----
  tile_map_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CODE_W (CODE_W)
  ) u_ram (
    .clk  (CLOCK_50),
    .we   (ram_we),
    .addr (ram_addr),
    .wd   (ram_wd),
    .rd   (ram_rd)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      rd_p1  <= 1'b0;
      lx_p1  <= '0;
      ly_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      rd_p1  <= pix_rd;
      lx_p1  <= lx_p0;
      ly_p1  <= ly_p0;
    end
  end

  // ---- stage 2: outputs; unread pixels (clear, out of range) show blank ----
  assign out_valid = vld_p1;
  assign out_code  = rd_p1 ? ram_rd : '0;
  assign out_loc_x = lx_p1;
  assign out_loc_y = ly_p1;

endmodule

// File: tb/tb_tile_map_renderer.sv
module tb_tile_map_renderer;

  localparam int DEPTH = 1200;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid;
  logic [9:0] x;
  logic [8:0] y;
  logic       out_valid;
  logic [3:0] out_code;
  logic [3:0] out_loc_x, out_loc_y;
  logic       wr_req;
  logic [5:0] wr_col;
  logic [4:0] wr_row;
  logic [3:0] wr_code;
  logic       wr_ack, wr_err, busy;
`ifdef TILE_SCROLL_EN
  logic [9:0] scroll_x;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_map_renderer dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .x         (x),
    .y         (y),
`ifdef TILE_SCROLL_EN
    .scroll_x  (scroll_x),
`endif
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_loc_x (out_loc_x),
    .out_loc_y (out_loc_y),
    .wr_req    (wr_req),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_code   (wr_code),
    .wr_ack    (wr_ack),
    .wr_err    (wr_err),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1; pix_valid = 1'b0; x = '0; y = '0;
    wr_req = 1'b0; wr_col = '0; wr_row = '0; wr_code = '0;
    repeat (3) tick;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || out_code !== 4'h0 ||
        out_loc_x !== 4'h0 || out_loc_y !== 4'h0 || wr_ack !== 1'b0 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b code=%h lx=%h ly=%h ack=%b err=%b, expected busy=1 rest 0",
               busy, out_valid, out_code, out_loc_x, out_loc_y, wr_ack, wr_err);
    end
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      tick;
      n++;
    end
    checks++;
    if (n != 1200) begin
      errors++;
      $display("FAIL clear_length: busy cycles=%0d, expected 1200", n);
    end
  endtask

  task automatic test_clear_scan;
    int r, c;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) begin
        r = i / 40; c = i % 40;
        pix_valid = 1'b1;
        x = 10'(c * 16 + c % 16);
        y = 9'(r * 16 + r % 16);
      end else begin
        pix_valid = 1'b0;
      end
      tick;
      if (i > 0) begin
        r = (i - 1) / 40; c = (i - 1) % 40;
        checks++;
        if (out_valid !== 1'b1 || out_code !== 4'h0 ||
            out_loc_x !== 4'(c % 16) || out_loc_y !== 4'(r % 16)) begin
          errors++;
          $display("FAIL clear_scan tile(%0d,%0d): valid=%b code=%h lx=%0d ly=%0d, expected 1 0 %0d %0d",
                   c, r, out_valid, out_code, out_loc_x, out_loc_y, c % 16, r % 16);
        end
      end
    end
  endtask

  task automatic test_write_read;
    wr_req = 1'b1; wr_col = 6'd3; wr_row = 5'd2; wr_code = 4'h5;
    #1;
    checks++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle_ack: ack=%b err=%b, expected 1 0", wr_ack, wr_err);
    end
    tick;
    wr_req = 1'b0;
    pix_valid = 1'b1; x = 10'd55; y = 9'd37;
    tick;
    pix_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: valid=%b one cycle after pixel, expected 0", out_valid);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 4'h5 || out_loc_x !== 4'd7 || out_loc_y !== 4'd5) begin
      errors++;
      $display("FAIL wr_read_3_2: valid=%b code=%h lx=%0d ly=%0d, expected 1 5 7 5",
               out_valid, out_code, out_loc_x, out_loc_y);
    end
    // last tile of the map
    wr_req = 1'b1; wr_col = 6'd39; wr_row = 5'd29; wr_code = 4'hA;
    #1;
    checks++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_last_ack: ack=%b err=%b, expected 1 0", wr_ack, wr_err);
    end
    tick;
    wr_req = 1'b0;
    pix_valid = 1'b1; x = 10'd639; y = 9'd479;
    tick;
    pix_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 4'hA || out_loc_x !== 4'd15 || out_loc_y !== 4'd15) begin
      errors++;
      $display("FAIL wr_read_39_29: valid=%b code=%h lx=%0d ly=%0d, expected 1 a 15 15",
               out_valid, out_code, out_loc_x, out_loc_y);
    end
  endtask

  task automatic test_write_starve;
    logic [3:0] exp_code;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        pix_valid = 1'b1; x = 10'(i * 16 + 2); y = 9'd37;
      end else begin
        pix_valid = 1'b0;
      end
      if (i == 1) begin
        wr_req = 1'b1; wr_col = 6'd5; wr_row = 5'd2; wr_code = 4'h9;
      end
      #1;
      if (i >= 1 && i <= 10) begin
        checks++;
        if (wr_ack !== 1'b0) begin
          errors++;
          $display("FAIL starve_noack cycle %0d: ack=%b, expected 0", i, wr_ack);
        end
      end
      if (i == 11) begin
        checks++;
        if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
          errors++;
          $display("FAIL starve_ack: ack=%b err=%b, expected 1 0", wr_ack, wr_err);
        end
      end
      if (i >= 2) begin
        exp_code = (i - 2 == 3) ? 4'h5 : 4'h0;
        checks++;
        if (out_valid !== 1'b1 || out_code !== exp_code || out_loc_x !== 4'd2 || out_loc_y !== 4'd5) begin
          errors++;
          $display("FAIL starve_stream pixel %0d: valid=%b code=%h lx=%0d ly=%0d, expected 1 %h 2 5",
                   i - 2, out_valid, out_code, out_loc_x, out_loc_y, exp_code);
        end
      end
      tick;
    end
    wr_req = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL starve_stream_end: valid=%b, expected 0", out_valid);
    end
    pix_valid = 1'b1; x = 10'd85; y = 9'd37;
    tick;
    pix_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 4'h9) begin
      errors++;
      $display("FAIL starve_written: valid=%b code=%h, expected 1 9", out_valid, out_code);
    end
  endtask

  task automatic test_write_oor;
    logic [9:0] px [3];
    logic [8:0] py [3];
    px[0] = 10'd0;   py[0] = 9'd16;
    px[1] = 10'd640; py[1] = 9'd0;
    px[2] = 10'd0;   py[2] = 9'd480;
    wr_req = 1'b1; wr_col = 6'd40; wr_row = 5'd0; wr_code = 4'hF;
    #1;
    checks++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_col_ack: ack=%b err=%b, expected 1 1", wr_ack, wr_err);
    end
    tick;
    wr_col = 6'd0; wr_row = 5'd30;
    #1;
    checks++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_row_ack: ack=%b err=%b, expected 1 1", wr_ack, wr_err);
    end
    tick;
    wr_req = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin
        pix_valid = 1'b1; x = px[i]; y = py[i];
      end else begin
        pix_valid = 1'b0;
      end
      tick;
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_code !== 4'h0 || out_loc_x !== 4'd0 || out_loc_y !== 4'd0) begin
          errors++;
          $display("FAIL oor_pixel %0d: valid=%b code=%h lx=%0d ly=%0d, expected 1 0 0 0",
                   i - 1, out_valid, out_code, out_loc_x, out_loc_y);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    int n, acks;
    pix_valid = 1'b1; x = 10'd639; y = 9'd479;
    tick;
    reset = 1'b1;
    pix_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_run: valid=%b busy=%b, expected 0 1", out_valid, busy);
    end
    tick; tick;
    reset = 1'b0;
    repeat (250) tick;
    // tile (39,29) still holds A in RAM, but pixels during clear read blank
    pix_valid = 1'b1; x = 10'd639; y = 9'd479;
    tick;
    pix_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 4'h0) begin
      errors++;
      $display("FAIL clear_pixel: valid=%b code=%h, expected 1 0", out_valid, out_code);
    end
    repeat (248) tick;
    wr_req = 1'b1; wr_col = 6'd1; wr_row = 5'd0; wr_code = 4'h3;
    #1;
    checks++;
    if (wr_ack !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_req: ack=%b busy=%b, expected 0 1", wr_ack, busy);
    end
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    n = 0; acks = 0;
    while (busy === 1'b1 && n < 3000) begin
      if (wr_ack === 1'b1) acks++;
      tick;
      n++;
    end
    checks++;
    if (n != 1200) begin
      errors++;
      $display("FAIL reclear_length: busy cycles=%0d, expected 1200", n);
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL reclear_noack: acks during clear=%0d, expected 0", acks);
    end
    checks++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL run_first_ack: ack=%b err=%b, expected 1 0", wr_ack, wr_err);
    end
    tick;
    wr_req = 1'b0;
    pix_valid = 1'b1; x = 10'd16; y = 9'd0;
    tick;
    x = 10'd55; y = 9'd37;
    tick;
    pix_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 4'h3) begin
      errors++;
      $display("FAIL reclear_written: valid=%b code=%h, expected 1 3", out_valid, out_code);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 4'h0) begin
      errors++;
      $display("FAIL reclear_wiped: valid=%b code=%h, expected 1 0", out_valid, out_code);
    end
  endtask

`ifdef TILE_SCROLL_EN
  task automatic test_scroll;
    wr_req = 1'b1; wr_col = 6'd0; wr_row = 5'd0; wr_code = 4'h7;
    #1;
    checks++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL scroll_wr_ack: ack=%b err=%b, expected 1 0", wr_ack, wr_err);
    end
    tick;
    wr_req = 1'b0;
    scroll_x = 10'd16;
    pix_valid = 1'b1; x = 10'd624; y = 9'd0;
    tick;
    x = 10'd3; y = 9'd0;
    tick;
    pix_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 4'h7 || out_loc_x !== 4'd0) begin
      errors++;
      $display("FAIL scroll_wrap: valid=%b code=%h lx=%0d, expected 1 7 0", out_valid, out_code, out_loc_x);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 4'h3 || out_loc_x !== 4'd3) begin
      errors++;
      $display("FAIL scroll_shift: valid=%b code=%h lx=%0d, expected 1 3 3", out_valid, out_code, out_loc_x);
    end
    scroll_x = 10'd0;
  endtask
`endif

  initial begin
`ifdef TILE_SCROLL_EN
    scroll_x = 10'd0;
`endif
    test_reset;
    test_clear_scan;
    test_write_read;
    test_write_starve;
    test_write_oor;
    test_reset_mid_clear;
`ifdef TILE_SCROLL_EN
    test_scroll;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_map_renderer.md
Name: tile_map_renderer

Overview:
- Parametrised tile-map fetch engine between the video driver's pixel coordinates and the pixel colour controller.
- Owns the tile map storage, an inferred single-port RAM of MAP_ROWS*MAP_COLS entries, each CODE_W bits wide.
- For each pixel, returns the tile code plus the in-tile pixel offset, pipelined to a fixed latency.
- Game logic updates individual tiles through a req/ack write port that is arbitrated against pixel reads. Example: a pellet is eaten and its tile becomes empty.

Parameters:
- TILE_LOG2, 4: tile edge is 2**TILE_LOG2 pixels (4 gives 16x16 tiles).
- MAP_COLS, 40: tiles per row.
- MAP_ROWS, 30: tile rows.
- CODE_W, 4: tile code width; code 0 means empty/blank.
- X_W, 10: pixel x width.
- Y_W, 9: pixel y width.
- Derived values (localparams, not overridable):
  - COL_W = $clog2(MAP_COLS)
  - ROW_W = $clog2(MAP_ROWS)
  - DEPTH = MAP_ROWS*MAP_COLS

Ports:
- CLOCK_50, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high.
- pix_valid, in, 1: x/y qualify a visible pixel this cycle.
- x, in, X_W: pixel column.
- y, in, Y_W: pixel row.
- out_valid, out, 1: pix_valid delayed 2 cycles.
- out_code, out, CODE_W: tile code for the pixel.
- out_loc_x, out, TILE_LOG2: x mod tile size.
- out_loc_y, out, TILE_LOG2: y mod tile size.
- wr_req, in, 1: tile write request; held with wr_* stable until wr_ack.
- wr_col, in, COL_W: target tile column.
- wr_row, in, ROW_W: target tile row.
- wr_code, in, CODE_W: new tile code.
- wr_ack, out, 1: one-cycle pulse; the request is consumed.
- wr_err, out, 1: pulses with wr_ack when the target is out of range.
- busy, out, 1: high while the map is being cleared.

Behaviour:
- Reset state:
  - All outputs 0, except busy=1.
  - Pipeline valids cleared.
  - FSM = CLEAR, clear address = 0.
- FSM states and transitions:
  - CLEAR: write code 0 to one address per cycle. After address DEPTH-1 is written, go to RUN on the next cycle and drop busy. Clearing takes DEPTH cycles (1200 at defaults).
  - RUN: normal operation. There is no path back to CLEAR except reset.
- Reset asserted mid-clear or mid-run: clear restarts at address 0 after reset releases. Any pending write is dropped and not acked.
- Pixel pipeline:
  - Stage 0 registers valid, col = x>>TILE_LOG2, row = y>>TILE_LOG2, and the loc bits. It computes addr = row*MAP_COLS + col.
  - Stage 1 is the RAM read. Stage 2 drives the outputs.
  - Fixed latency: 2 cycles from pix_valid to out_valid. Back-to-back pixels are accepted every cycle.
- Out of range: when col >= MAP_COLS or row >= MAP_ROWS, the RAM is not read and out_code=0. out_valid and loc still follow the pixel.
- Pixels during CLEAR: out_valid still follows pix_valid, and out_code is forced to 0.
- Write arbitration (RUN only):
  - The RAM port goes to the pixel read when a stage-0 valid pixel needs it. Otherwise it goes to a pending wr_req.
  - Once the write occurs, wr_ack pulses in that same cycle. The requester may drop or change wr_req on the next cycle.
  - A write with wr_col >= MAP_COLS or wr_row >= MAP_ROWS does not touch the RAM and gets wr_ack=1 and wr_err=1 in the first free cycle.
- Requests during CLEAR are never acked; they wait for RUN.
- Read-after-write: a pixel read of the same address in any cycle after the write cycle returns the new code. There is no same-cycle hazard, because the port is single-access.
- Widths: addr is $clog2(DEPTH) bits. The multiply is by a constant and must not truncate the column.
- Starvation: a write can starve during continuous pix_valid. Callers rely on horizontal blanking, where pix_valid is low for 160 cycles per line at 640x480.

Optional Feature:
- Macro: TILE_SCROLL_EN.
- Defined: adds input scroll_x [X_W].
  - Stage 0 uses xe = (x + scroll_x) mod (MAP_COLS<<TILE_LOG2), a wrapping horizontal scroll. col and out_loc_x come from xe.
  - scroll_x is sampled together with the pixel. Latency is unchanged.
- Undefined: port absent; xe = x.

Decomposition:
- Package tile_map_pkg: tile code typedef (CODE_W default 4), TILE_EMPTY = 0, and FSM enum {CLEAR, RUN}.
- One natural sub-module: tile_map_ram, an inferred single-port synchronous RAM with 1-cycle read, no reset on contents. The FSM, arbitration and pipeline stay in the parent.

Test Plan:
- Reset release: busy=1 for exactly 1200 cycles, then 0. A subsequent scan of all tiles returns out_code=0 everywhere.
- Write tile (col 3, row 2) = 4'h5 during idle → wr_ack in the same cycle, wr_err=0. Pixel (x=55, y=37) → 2 cycles later out_code=5, out_loc_x=7, out_loc_y=5.
- wr_req held during 10 consecutive pix_valid cycles → no ack for those 10 cycles; ack on the first cycle with no stage-0 pixel. out_valid stream is unbroken.
- wr_col=40 → wr_ack=1 with wr_err=1, RAM unchanged. Pixel x=640 (col 40) → out_code=0, out_valid=1.
- Reset pulse 500 cycles into clear → busy stays high a full 1200 cycles after release. A pending wr_req is not acked until RUN.
- TILE_SCROLL_EN with scroll_x=16 and tile (0,0)=7 → pixel x=624, y=0 gives out_code=7 (wrapped).
